bt656_rx: RTL and testbench
===========================

# bt656_rx

ITU-R BT.656 receiver for the 8-bit stream from the TV decoder (TD_DATA). It hunts for EAV/SAV timing reference codes, tracks the F/V/H flags, and demultiplexes active-video bytes (Cb Y0 Cr Y1) into 4:2:2 pixel pairs. Each pair carries a pair index, an active-line index and the field bit. It sits directly upstream of the VGA output stage and feeds the line buffer/scaler in front of the VGA timing generator.

## Interface
- ACTIVE_PAIRS, 360, maximum pixel pairs accepted per active line (720 luma samples).
- LINE_W, 10, width of the active-line counter.
- clk  in  1  decoder byte clock (TD_CLK domain, 27 MHz); all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- td_data  in  8  BT.656 byte stream from the TV decoder.
- out_y0, out_y1  out  8 each  luma of even and odd pixel in the pair.
- out_cb, out_cr  out  8 each  shared chroma of the pair.
- out_valid  out  1  one-cycle strobe when a pair is presented.
- out_x  out  9  pair index within the line, 0..ACTIVE_PAIRS-1.
- out_line  out  LINE_W  active-line index within the field.
- out_field  out  1  F bit of the current line.
- sof  out  1  high with out_valid on pair 0 of line 0 of each field.
- sync_lock  out  1  high once a valid EAV/SAV has been decoded.
- err_cnt  out  8  saturating count of rejected timing codes.

## Operation
- Preamble detect: 3-byte history register. The sequence FF,00,00 followed by byte XY forms a timing code. XY bits are 1,F,V,H,P3,P2,P1,P0.
- H=1 means EAV; H=0 means SAV.
- States:
  - HUNT (reset): waiting for the first valid code.
  - BLANK: between EAV and SAV, or SAV with V=1.
  - ACTIVE: after an SAV with V=0.
- Transitions: a valid SAV with V=0 moves to ACTIVE, from any state. A valid EAV moves to BLANK. A valid SAV with V=1 moves to BLANK.
- In ACTIVE, a 2-bit phase counter starts at 0 on the byte after XY and cycles through Cb, Y0, Cr, Y1.
- Preamble bytes are never captured as pixel data. An ACTIVE byte that completes FF,00,00 causes the partial pair to be discarded.
- out_x:
  - Cleared at SAV; increments after each emitted pair.
  - Pairs beyond ACTIVE_PAIRS are dropped with no strobe until the next EAV.
- out_line:
  - Set to 0 at the first V=0 SAV following a V=1 line, or following a change of F.
  - Increments at each subsequent V=0 SAV.
  - Wraps modulo 2^LINE_W.
- out_field is latched from F at each valid SAV.
- sof is asserted when out_line==0 and out_x==0 on the emitted pair.
- sync_lock is set by the first valid code and cleared only by reset.
- Data outputs hold their last value between strobes.

## Timing
- Reset values: all outputs 0; state HUNT.
- Reset asserted mid-line: immediately to HUNT. The first pair after reset release requires a fresh valid SAV.
- Latency: out_valid is high for exactly one cycle, on the rising edge after the Y1 byte is sampled. That is, 1 cycle after Y1 and 4 cycles after Cb. out_* are registered.
- Strobe rate: at most 1 per 4 clk cycles; never back-to-back.
- XY decode takes effect on the edge sampling XY. State and counters update on that same edge.
- An EAV arriving at phase ≠ 0 aborts the partial pair (no strobe) and enters BLANK.

## Configuration
- BT656_PROT_CHECK_EN defined:
  - XY is valid only if bit7=1 and P3=V^H, P2=F^H, P1=F^V, P0=F^V^H.
  - An invalid code forces HUNT, does not alter F/V/H, and increments err_cnt, saturating at 255.
- Undefined:
  - P bits and bit7 are ignored; every FF,00,00,XY is accepted.
  - err_cnt is tied to 0.

## Test plan
- Reset, then SAV 0x80 (F0 V0), then bytes 10,20,30,40 ×360, then EAV 0x9D:
  - 360 strobes, first with cb=10, y0=20, cr=30, y1=40, out_x=0, out_line=0, sof=1.
  - Last strobe has out_x=359.
  - State BLANK after EAV.
- Two consecutive lines, V=1 line (SAV 0xAB) then V=0 line (SAV 0x80):
  - No strobes on the V=1 line.
  - out_line=0 on the V=0 line; the next V=0 line gives out_line=1.
- SAV 0x80, 5 bytes, then FF,00,00,9D:
  - Exactly 1 strobe; the trailing byte is discarded.
  - BLANK; out_x cleared at the next SAV.
- Line of 362 pairs: strobes stop after out_x=359; none until EAV.
- BT656_PROT_CHECK_EN with XY=0x81 (bad P0) after a lock:
  - state HUNT, err_cnt 0→1, no strobes until a valid SAV.
  - Without the macro, the same code enters ACTIVE.
- Assert rst_n low for 1 cycle during phase 2 of an active line: outputs 0, sync_lock=0, no strobe until the next valid SAV.

Source files
------------

// File: rtl/bt656_rx.sv
// ---------------------------------------------------------------------------
// bt656_rx -- ITU-R BT.656 receiver
//
// Hunts the 8-bit decoder byte stream for FF,00,00,XY timing reference codes,
// tracks the F/V/H flags and splits active video (Cb Y0 Cr Y1) into 4:2:2
// pixel pairs. Each pair is tagged with its index within the line, the
// active-line index within the field and the field bit.
//
// Parameters:
//   ACTIVE_PAIRS  maximum pixel pairs accepted per active line (default 360)
//   LINE_W        width of the active-line counter (default 10)
//
// Ports:
//   clk           decoder byte clock; all logic on the rising edge
//   rst_n         asynchronous active-low reset
//   td_data[7:0]  BT.656 byte stream
//   out_y0/out_y1 luma of the even / odd pixel of the pair
//   out_cb/out_cr shared chroma of the pair
//   out_valid     one-cycle strobe when a pair is presented
//   out_x[8:0]    pair index within the line
//   out_line      active-line index within the field
//   out_field     F bit of the current line
//   sof           with out_valid on pair 0 of line 0 of a field
//   sync_lock     set by the first accepted timing code, cleared by reset
//   err_cnt[7:0]  saturating count of rejected timing codes
//   state_dbg[1:0] current receiver state (0 HUNT, 1 BLANK, 2 ACTIVE)
//
// Optional feature: define BT656_PROT_CHECK_EN to validate the XY protection
// bits. Without it every FF,00,00,XY is accepted and err_cnt is tied to 0.
//
// Output handshake: out_valid is a single-cycle strobe with no back-pressure.
// All out_* fields are registered and are meaningful in the cycle out_valid
// is high; the data fields hold their last value between strobes. The sink
// must accept a pair in every cycle out_valid is high.
// ---------------------------------------------------------------------------
module bt656_rx #(
  parameter int ACTIVE_PAIRS = 360,
  parameter int LINE_W       = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        td_data,
  output logic [7:0]        out_y0,
  output logic [7:0]        out_y1,
  output logic [7:0]        out_cb,
  output logic [7:0]        out_cr,
  output logic              out_valid,
  output logic [8:0]        out_x,
  output logic [LINE_W-1:0] out_line,
  output logic              out_field,
  output logic              sof,
  output logic              sync_lock,
  output logic [7:0]        err_cnt,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_BLANK  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  localparam logic [8:0] MAX_X = 9'(ACTIVE_PAIRS);

  state_t      state_q, state_d;

  // Byte history: hist2_q is the oldest of the last three bytes.
  logic [7:0]  hist2_q, hist1_q, hist0_q;

  logic [1:0]  phase_q;        // 0 Cb, 1 Y0, 2 Cr, 3 Y1
  logic [8:0]  x_cnt_q;        // index of the next pair in the line
  logic [7:0]  cb_q, y0_q, cr_q;
  logic        last_sav_v_q;   // V bit of the most recent accepted SAV

  logic        is_xy;          // current byte sits in the XY slot
  logic        pre_done;       // current byte completes FF,00,00
  logic        pre_open;       // current byte may be the start of a preamble
  logic        code_ok;
  logic        code_valid;
  logic        code_bad;
  logic        xy_f, xy_v, xy_h;
  logic        is_sav;
  logic        capture;
  logic        emit;

  // -------------------------------------------------------------------------
  // Timing reference decode
  // -------------------------------------------------------------------------
  assign is_xy    = (hist2_q == 8'hFF) && (hist1_q == 8'h00) && (hist0_q == 8'h00);
  assign pre_done = (hist1_q == 8'hFF) && (hist0_q == 8'h00) && (td_data == 8'h00);

  // 00 and FF are reserved in legal video. A Y1 byte of FF, or a 00 right
  // after an FF, is the head of a timing preamble rather than pixel data, so
  // the pair it would close is withheld instead of presenting preamble bytes.
  assign pre_open = (td_data == 8'hFF) || ((hist0_q == 8'hFF) && (td_data == 8'h00));

  assign xy_f = td_data[6];
  assign xy_v = td_data[5];
  assign xy_h = td_data[4];

`ifdef BT656_PROT_CHECK_EN
  assign code_ok = td_data[7]
                && (td_data[3] == (xy_v ^ xy_h))
                && (td_data[2] == (xy_f ^ xy_h))
                && (td_data[1] == (xy_f ^ xy_v))
                && (td_data[0] == (xy_f ^ xy_v ^ xy_h));
`else
  assign code_ok = 1'b1;
`endif

  assign code_valid = is_xy && code_ok;
  assign code_bad   = is_xy && !code_ok;
  assign is_sav     = code_valid && !xy_h;

  // -------------------------------------------------------------------------
  // Receiver state machine
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (code_bad) begin
      state_d = S_HUNT;
    end else if (code_valid) begin
      if (xy_h || xy_v) begin
        state_d = S_BLANK;
      end else begin
        state_d = S_ACTIVE;
      end
    end
  end

  assign state_dbg = state_q;

  // A byte is pixel data only in ACTIVE and only if it is neither the XY
  // code itself nor the byte that completes a preamble (which aborts the
  // partial pair).
  assign capture = (state_q == S_ACTIVE) && !is_xy && !pre_done;
  assign emit    = capture && (phase_q == 2'd3) && !pre_open && (x_cnt_q != MAX_X);

  // -------------------------------------------------------------------------
  // Byte history
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist2_q <= 8'h00;
      hist1_q <= 8'h00;
      hist0_q <= 8'h00;
    end else begin
      hist2_q <= hist1_q;
      hist1_q <= hist0_q;
      hist0_q <= td_data;
    end
  end

  // -------------------------------------------------------------------------
  // Phase counter and chroma/luma staging
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 2'd0;
      cb_q    <= 8'h00;
      y0_q    <= 8'h00;
      cr_q    <= 8'h00;
    end else if (!capture) begin
      // Any non-pixel byte (code, aborting preamble byte, blanking) puts the
      // next pixel byte back on Cb.
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_q + 2'd1;
      unique case (phase_q)
        2'd0:    cb_q <= td_data;
        2'd1:    y0_q <= td_data;
        2'd2:    cr_q <= td_data;
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Pair output, pair/line counters and field tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_y0       <= 8'h00;
      out_y1       <= 8'h00;
      out_cb       <= 8'h00;
      out_cr       <= 8'h00;
      out_valid    <= 1'b0;
      out_x        <= 9'd0;
      out_line     <= '0;
      out_field    <= 1'b0;
      sof          <= 1'b0;
      x_cnt_q      <= 9'd0;
      // Reset behaves like the end of a vertical-blanking line so the first
      // active line after reset is numbered 0.
      last_sav_v_q <= 1'b1;
    end else begin
      out_valid <= emit;
      sof       <= emit && (out_line == '0) && (x_cnt_q == 9'd0);

      if (is_sav) begin
        out_field    <= xy_f;
        last_sav_v_q <= xy_v;
        out_x        <= 9'd0;
        x_cnt_q      <= 9'd0;
        if (!xy_v) begin
          // Restart numbering on the first active line of a field: after a
          // blanking line or when F flips; otherwise count up.
          if (last_sav_v_q || (xy_f != out_field)) begin
            out_line <= '0;
          end else begin
            out_line <= out_line + LINE_W'(1);
          end
        end
      end else if (emit) begin
        out_cb  <= cb_q;
        out_y0  <= y0_q;
        out_cr  <= cr_q;
        out_y1  <= td_data;
        out_x   <= x_cnt_q;
        x_cnt_q <= x_cnt_q + 9'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Lock and error tracking
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_lock <= 1'b0;
    end else if (code_valid) begin
      sync_lock <= 1'b1;
    end
  end

`ifdef BT656_PROT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'h00;
    end else if (code_bad && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_bt656_rx.sv
// ---------------------------------------------------------------------------
// tb_bt656_rx -- self-checking bench for bt656_rx
//
// Drivers build BT.656 lines byte by byte; a line-level reference model
// derives which pairs must appear (with index, line number, field and sof)
// and pushes them into exp_q. An independent monitor pops and compares on
// every out_valid strobe.
// ---------------------------------------------------------------------------
module tb_bt656_rx;

  localparam int ACTIVE_PAIRS = 360;
  localparam int LINE_W       = 10;
  localparam int W            = 53;  // cb,y0,cr,y1,x[9],line[10],field,sof

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_BLANK  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [7:0]        td_data = 8'h00;

  logic [7:0]        out_y0, out_y1, out_cb, out_cr;
  logic              out_valid;
  logic [8:0]        out_x;
  logic [LINE_W-1:0] out_line;
  logic              out_field, sof, sync_lock;
  logic [7:0]        err_cnt;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  bt656_rx #(.ACTIVE_PAIRS(ACTIVE_PAIRS), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .td_data   (td_data),
    .out_y0    (out_y0),
    .out_y1    (out_y1),
    .out_cb    (out_cb),
    .out_cr    (out_cr),
    .out_valid (out_valid),
    .out_x     (out_x),
    .out_line  (out_line),
    .out_field (out_field),
    .sof       (sof),
    .sync_lock (sync_lock),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int n_strobes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        n_strobes++;
        check("strobe_spacing", {63'd0, prev_valid}, 64'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_strobe: got x=%0d line=%0d expected no strobe at %0t",
                   out_x, out_line, $time);
        end else begin
          check("pair", {out_cb, out_y0, out_cr, out_y1, out_x, out_line, out_field, sof},
                exp_q.pop_front());
        end
      end
      prev_valid = out_valid;
    end
  end

  // ---------------- reference model ----------------
  logic [LINE_W-1:0] m_line;
  logic              m_prev_v;
  logic              m_field;
  logic [7:0]        m_err;
  logic              m_lock;

  task automatic model_reset();
    m_line   = '0;
    m_prev_v = 1'b1;
    m_field  = 1'b0;
    m_err    = 8'd0;
    m_lock   = 1'b0;
  endtask

  // The eight legal BT.656 XY words (F,V,H combinations with correct parity).
  function automatic bit code_accepted(input logic [7:0] xy);
`ifdef BT656_PROT_CHECK_EN
    logic [7:0] legal [8];
    legal = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};
    foreach (legal[i]) if (legal[i] == xy) return 1'b1;
    return 1'b0;
`else
    return (xy != 8'hFF) || 1'b1;
`endif
  endfunction

  function automatic logic [7:0] rnd_px();
    return 8'($urandom_range(1, 254));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    td_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_code(input logic [7:0] xy);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(xy);
  endtask

  task automatic send_blank(input int n);
    for (int i = 0; i < n; i++) send_byte((i % 2 == 0) ? 8'h80 : 8'h10);
  endtask

  // Sends an SAV and updates the model; act says whether pairs will be emitted.
  task automatic start_line(input logic [7:0] sav, output bit act);
    send_code(sav);
    act = 1'b0;
    if (!code_accepted(sav)) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
    end else begin
      m_lock = 1'b1;
      if (!sav[5]) begin
        if (m_prev_v || (sav[6] != m_field)) m_line = '0;
        else m_line = m_line + LINE_W'(1);
        act = 1'b1;
      end
      m_prev_v = sav[5];
      m_field  = sav[6];
    end
  endtask

  task automatic send_pairs(input bit act, input int n, input bit fixed);
    logic [7:0] cb, y0, cr, y1;
    for (int i = 0; i < n; i++) begin
      if (fixed) begin
        cb = 8'h10; y0 = 8'h20; cr = 8'h30; y1 = 8'h40;
      end else begin
        cb = rnd_px(); y0 = rnd_px(); cr = rnd_px(); y1 = rnd_px();
      end
      send_byte(cb);
      send_byte(y0);
      send_byte(cr);
      if (act && i < ACTIVE_PAIRS)
        exp_q.push_back({cb, y0, cr, y1, 9'(i), m_line, m_field, (m_line == '0) && (i == 0)});
      send_byte(y1);
    end
  endtask

  // Optional partial pair (discarded) then EAV.
  task automatic finish_line(input int extra, input logic [7:0] eav);
    for (int j = 0; j < extra; j++) send_byte(rnd_px());
    send_code(eav);
    if (code_accepted(eav)) m_lock = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] sav_tab [4];
  logic [7:0] eav_tab [4];

  initial begin
    bit act;
    int k;
    sav_tab = '{8'h80, 8'hAB, 8'hC7, 8'hEC};
    eav_tab = '{8'h9D, 8'hB6, 8'hDA, 8'hF1};
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_x", {55'd0, out_x}, 64'd0);
    check("rst_line", {54'd0, out_line}, 64'd0);
    check("rst_field", {63'd0, out_field}, 64'd0);
    check("rst_sof", {63'd0, sof}, 64'd0);
    check("rst_lock", {63'd0, sync_lock}, 64'd0);
    check("rst_err", {56'd0, err_cnt}, 64'd0);
    check("rst_state", {62'd0, state_dbg}, {62'd0, ST_HUNT});
    check("rst_data", {32'd0, out_cb, out_y0, out_cr, out_y1}, 64'd0);
    rst_n = 1'b1;
    send_blank(4);

    // Full line of fixed pattern
    start_line(8'h80, act);
    check("sav_state", {62'd0, state_dbg}, {62'd0, ST_ACTIVE});
    send_pairs(act, ACTIVE_PAIRS, 1'b1);
    finish_line(0, 8'h9D);
    check("eav_state", {62'd0, state_dbg}, {62'd0, ST_BLANK});
    check("last_x", {55'd0, out_x}, 64'd359);
    check("lock_after_code", {63'd0, sync_lock}, {63'd0, m_lock});
    send_blank(6);

    // V=1 line, then two V=0 lines, then an F change
    start_line(8'hAB, act);
    send_pairs(act, 12, 1'b0);
    finish_line(0, 8'hB6);
    send_blank(4);
    start_line(8'h80, act);
    send_pairs(act, 8, 1'b0);
    finish_line(0, 8'h9D);
    check("line0_after_v1", {54'd0, out_line}, 64'd0);
    send_blank(4);
    start_line(8'h80, act);
    send_pairs(act, 8, 1'b0);
    finish_line(0, 8'h9D);
    check("line1", {54'd0, out_line}, 64'd1);
    start_line(8'hC7, act);
    send_pairs(act, 4, 1'b0);
    finish_line(0, 8'hDA);
    check("line0_after_f", {54'd0, out_line}, 64'd0);

    // SAV, 5 bytes, EAV: one strobe, trailing byte dropped
    start_line(8'h80, act);
    send_pairs(act, 1, 1'b0);
    finish_line(1, 8'h9D);
    check("short_state", {62'd0, state_dbg}, {62'd0, ST_BLANK});

    // Overlong line: strobes stop after index 359
    start_line(8'h80, act);
    send_pairs(act, ACTIVE_PAIRS + 2, 1'b0);
    check("overlong_x", {55'd0, out_x}, 64'd359);
    finish_line(0, 8'h9D);
    start_line(8'hC7, act);
    check("x_clear_at_sav", {55'd0, out_x}, 64'd0);
    send_pairs(act, 3, 1'b0);
    finish_line(2, 8'hDA);

    // Randomised lines with aborted partial pairs
    for (int n = 0; n < 14; n++) begin
      k = $urandom_range(0, 3);
      send_blank($urandom_range(0, 5));
      start_line(sav_tab[k], act);
      send_pairs(act, $urandom_range(1, 30), 1'b0);
      finish_line($urandom_range(0, 3), eav_tab[k]);
    end

    // Bad-protection code after lock
    send_blank(2);
    start_line(8'h81, act);
`ifdef BT656_PROT_CHECK_EN
    check("bad_code_state", {62'd0, state_dbg}, {62'd0, ST_HUNT});
`else
    check("bad_code_state", {62'd0, state_dbg}, {62'd0, ST_ACTIVE});
`endif
    check("bad_code_err", {56'd0, err_cnt}, {56'd0, m_err});
    send_pairs(act, 6, 1'b0);
    finish_line(0, 8'h9D);
    start_line(8'h80, act);
    send_pairs(act, 5, 1'b0);
    finish_line(0, 8'h9D);

    // Reset pulse during phase 2 of an active line
    start_line(8'h80, act);
    send_pairs(act, 3, 1'b0);
    send_byte(rnd_px());
    send_byte(rnd_px());
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_x", {55'd0, out_x}, 64'd0);
    check("midrst_data", {32'd0, out_cb, out_y0, out_cr, out_y1}, 64'd0);
    check("midrst_lock", {63'd0, sync_lock}, 64'd0);
    check("midrst_state", {62'd0, state_dbg}, {62'd0, ST_HUNT});
    check("midrst_pending", exp_q.size(), 64'd0);
    model_reset();
    send_byte(rnd_px());
    rst_n = 1'b1;
    send_byte(rnd_px());
    send_pairs(1'b0, 4, 1'b0);
    check("postrst_lock", {63'd0, sync_lock}, 64'd0);
    finish_line(0, 8'h9D);
    check("relock", {63'd0, sync_lock}, {63'd0, m_lock});
    start_line(8'h80, act);
    send_pairs(act, 6, 1'b0);
    finish_line(0, 8'h9D);

    // Drain and report
    send_blank(8);
    check("exp_q_empty", exp_q.size(), 64'd0);
    check("strobes_seen_nonzero", {63'd0, (n_strobes > 400)}, 64'd1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
